// File: rtl/alu_issue_unit_pkg.sv
// rtl/alu_issue_unit_pkg.sv - opcodes, FSM states and flag layout for the ALU issue unit
package alu_issue_unit_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   localparam int FLAG_EQ = 2;
   localparam int FLAG_GT = 1;
   localparam int FLAG_LT = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   function automatic logic [2:0] pack_flags(input logic eq, input logic gt, input logic lt);
      logic [2:0] f;
      f          = 3'b000;
      f[FLAG_EQ] = eq;
      f[FLAG_GT] = gt;
      f[FLAG_LT] = lt;
      return f;
   endfunction

endpackage

// File: rtl/alu_issue_unit_op_fifo.sv
// rtl/alu_issue_unit_op_fifo.sv - synchronous op FIFO, registered flags, no push/pop bypass
module alu_issue_unit_op_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
         if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
         else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - registered issue/capture stage around a combinational 4-bit ALU
module alu_issue_unit
   import alu_issue_unit_pkg::*;
#(
   parameter int DATA_W        = 4,
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [1:0]        in_op_i,
   input  logic [DATA_W-1:0] in_a_i,
   input  logic [DATA_W-1:0] in_b_i,
   output logic              alu_s0_o,
   output logic              alu_s1_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   input  logic [DATA_W:0]   alu_sum_i,
   input  logic              alu_eq_i,
   input  logic              alu_gt_i,
   input  logic              alu_lt_i,
   input  logic [DATA_W-1:0] alu_and_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [1:0]        out_op_o,
   output logic [DATA_W:0]   out_data_o,
   output logic [2:0]        out_flags_o
);

   localparam int ENTRY_W = 2 + 2*DATA_W;
   localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic                out_valid_q, out_valid_d;
   logic [1:0]          out_op_q, out_op_d;
   logic [DATA_W:0]     out_data_q, out_data_d;
   logic [2:0]          out_flags_q, out_flags_d;

   logic                fifo_full, fifo_empty, fifo_pop, load_alu;
   logic [ENTRY_W-1:0]  fifo_rdata;
   logic [DATA_W:0]     res_data;
   logic [2:0]          res_flags;

   alu_issue_unit_op_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (in_valid_i),
      .wdata_i ({in_op_i, in_a_i, in_b_i}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign in_ready_o  = !fifo_full;
   assign alu_s0_o    = op_q[0];
   assign alu_s1_o    = op_q[1];
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign out_valid_o = out_valid_q;
   assign out_op_o    = out_op_q;
   assign out_data_o  = out_data_q;
   assign out_flags_o = out_flags_q;

   always_comb begin
      res_data  = '0;
      res_flags = 3'b000;
      case (op_q)
         OP_ADD, OP_SUB: res_data  = alu_sum_i;
         OP_CMP:         res_flags = pack_flags(alu_eq_i, alu_gt_i, alu_lt_i);
         OP_AND:         res_data  = {1'b0, alu_and_i};
         default:        res_data  = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q && !out_ready_i;
      out_op_d    = out_op_q;
      out_data_d  = out_data_q;
      out_flags_d = out_flags_q;
      load_alu    = 1'b0;
      fifo_pop    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               load_alu = 1'b1;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_CAPTURE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         ST_CAPTURE: begin
            // a held result must be taken before it can be overwritten
            if (!(out_valid_q && !out_ready_i)) begin
               out_valid_d = 1'b1;
               out_op_d    = op_q;
               out_data_d  = res_data;
               out_flags_d = res_flags;
               if (!fifo_empty) begin
                  load_alu = 1'b1;
                  state_d  = ST_SETTLE;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_alu) begin
         fifo_pop = 1'b1;
         op_d     = fifo_rdata[ENTRY_W-1 -: 2];
         a_d      = fifo_rdata[2*DATA_W-1 -: DATA_W];
         b_d      = fifo_rdata[DATA_W-1:0];
         cnt_d    = CNT_INIT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_op_q    <= '0;
         out_data_q  <= '0;
         out_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         out_op_q    <= out_op_d;
         out_data_q  <= out_data_d;
         out_flags_q <= out_flags_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed self-checking bench for alu_issue_unit
module tb_alu_issue_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [1:0] in_op, out_op;
   logic [3:0] in_a, in_b, alu_a, alu_b, alu_and;
   logic       alu_s0, alu_s1, alu_eq, alu_gt, alu_lt;
   logic [4:0] alu_sum, out_data;
   logic [2:0] out_flags;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [1:0] g_op    [16];
   logic [4:0] g_data  [16];
   logic [2:0] g_flags [16];
   int         g_cyc   [16];
   int         got_n;

   logic [1:0] t_op    [8];
   logic [3:0] t_a     [8];
   logic [3:0] t_b     [8];
   logic [4:0] t_data  [8];
   logic [2:0] t_flags [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // behavioural model of the external combinational ALU
   always_comb begin
      alu_sum = alu_s0 ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1) : ({1'b0, alu_a} + {1'b0, alu_b});
      alu_eq  = (alu_a == alu_b);
      alu_gt  = (alu_a > alu_b);
      alu_lt  = (alu_a < alu_b);
      alu_and = alu_a & alu_b;
   end

   alu_issue_unit #(.DATA_W(4), .DEPTH(4), .SETTLE_CYCLES(1)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_op_i     (in_op),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .alu_s0_o    (alu_s0),
      .alu_s1_o    (alu_s1),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_sum_i   (alu_sum),
      .alu_eq_i    (alu_eq),
      .alu_gt_i    (alu_gt),
      .alu_lt_i    (alu_lt),
      .alu_and_i   (alu_and),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_op_o    (out_op),
      .out_data_o  (out_data),
      .out_flags_o (out_flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      bit acc;
      int guard;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      guard    = 0;
      do begin
         acc = in_ready;
         tick();
         guard++;
      end while (!acc && guard < 50);
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL push_timeout got=in_ready_low exp=accepted");
      end
   endtask

   task automatic collect(input int n, input int budget);
      int k;
      got_n = 0;
      k = 0;
      while (got_n < n && k < budget) begin
         if (out_valid && out_ready && got_n < 16) begin
            g_op[got_n]    = out_op;
            g_data[got_n]  = out_data;
            g_flags[got_n] = out_flags;
            g_cyc[got_n]   = cyc;
            got_n++;
         end
         tick();
         k++;
      end
      checks++;
      if (got_n != n) begin
         failures++;
         $display("FAIL collect_count got=%0d exp=%0d", got_n, n);
      end
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if ({alu_s1, alu_s0, alu_a, alu_b} !== 10'd0) begin failures++; $display("FAIL rst_alu got=%h exp=0", {alu_s1, alu_s0, alu_a, alu_b}); end
      checks++; if ({out_op, out_data, out_flags} !== 10'd0) begin failures++; $display("FAIL rst_out got=%h exp=0", {out_op, out_data, out_flags}); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      out_ready = 1'b1;
      push_op(2'b00, 4'd9, 4'd8);
      tick();
      checks++; if ({alu_a, alu_b} !== 8'h98) begin failures++; $display("FAIL mid_alu_loaded got=%h exp=98", {alu_a, alu_b}); end
      rst_n = 1'b0;
      #1;
      checks++; if ({alu_s1, alu_s0, alu_a, alu_b} !== 10'd0) begin failures++; $display("FAIL mid_rst_alu got=%h exp=0", {alu_s1, alu_s0, alu_a, alu_b}); end
      checks++; if ({out_valid, out_op, out_data, out_flags} !== 11'd0) begin failures++; $display("FAIL mid_rst_out got=%h exp=0", {out_valid, out_op, out_data, out_flags}); end
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_no_result got=%b exp=0", seen); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      push_op(2'b00, 4'd9, 4'd8);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_lat_e1 got=%b exp=0", out_valid); end
      tick();
      checks++; if ({alu_s1, alu_s0, alu_a, alu_b} !== 10'b00_1001_1000) begin failures++; $display("FAIL add_alu_drive got=%b exp=0010011000", {alu_s1, alu_s0, alu_a, alu_b}); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_lat_e2 got=%b exp=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_lat_e3 got=%b exp=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_lat_valid got=%b exp=1", out_valid); end
      checks++; if ({out_op, out_data, out_flags} !== {2'b00, 5'b10001, 3'b000}) begin failures++; $display("FAIL add_result got=%b exp=0010001000", {out_op, out_data, out_flags}); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drop got=%b exp=0", out_valid); end
   endtask

   task automatic test_sub();
      out_ready = 1'b1;
      push_op(2'b01, 4'd3, 4'd5);
      push_op(2'b01, 4'd5, 4'd3);
      collect(2, 40);
      checks++; if (g_data[0] !== 5'b01110) begin failures++; $display("FAIL sub_3_5 got=%b exp=01110", g_data[0]); end
      checks++; if (g_data[1] !== 5'b10010) begin failures++; $display("FAIL sub_5_3 got=%b exp=10010", g_data[1]); end
      checks++; if ({g_op[1], g_flags[1]} !== 5'b01_000) begin failures++; $display("FAIL sub_op_flags got=%b exp=01000", {g_op[1], g_flags[1]}); end
   endtask

   task automatic test_cmp();
      out_ready = 1'b1;
      push_op(2'b10, 4'd6, 4'd6);
      push_op(2'b10, 4'd9, 4'd3);
      push_op(2'b10, 4'd2, 4'd7);
      collect(3, 60);
      checks++; if ({g_data[0], g_flags[0]} !== {5'd0, 3'b100}) begin failures++; $display("FAIL cmp_eq got=%b exp=00000100", {g_data[0], g_flags[0]}); end
      checks++; if ({g_data[1], g_flags[1]} !== {5'd0, 3'b010}) begin failures++; $display("FAIL cmp_gt got=%b exp=00000010", {g_data[1], g_flags[1]}); end
      checks++; if ({g_data[2], g_flags[2]} !== {5'd0, 3'b001}) begin failures++; $display("FAIL cmp_lt got=%b exp=00000001", {g_data[2], g_flags[2]}); end
      checks++; if (g_op[2] !== 2'b10) begin failures++; $display("FAIL cmp_op got=%b exp=10", g_op[2]); end
   endtask

   task automatic test_and_stall();
      int n;
      t_op[0] = 2'b00; t_a[0] = 4'h1; t_b[0] = 4'h2; t_data[0] = 5'b00011; t_flags[0] = 3'b000;
      t_op[1] = 2'b01; t_a[1] = 4'h7; t_b[1] = 4'h2; t_data[1] = 5'b10101; t_flags[1] = 3'b000;
      t_op[2] = 2'b10; t_a[2] = 4'h4; t_b[2] = 4'h9; t_data[2] = 5'b00000; t_flags[2] = 3'b001;
      t_op[3] = 2'b11; t_a[3] = 4'hf; t_b[3] = 4'h6; t_data[3] = 5'b00110; t_flags[3] = 3'b000;
      t_op[4] = 2'b00; t_a[4] = 4'hf; t_b[4] = 4'hf; t_data[4] = 5'b11110; t_flags[4] = 3'b000;
      for (int i = 5; i < 8; i++) begin
         t_op[i] = 2'b00; t_a[i] = 4'h0; t_b[i] = 4'h0; t_data[i] = 5'd0; t_flags[i] = 3'b000;
      end
      out_ready = 1'b0;
      push_op(2'b11, 4'b1101, 4'b1011);
      n = 0;
      while (in_ready && n < 8) begin
         push_op(t_op[n], t_a[n], t_b[n]);
         n++;
      end
      checks++; if (n !== 5) begin failures++; $display("FAIL fill_count got=%0d exp=5", n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid, out_op, out_data, out_flags} !== {1'b1, 2'b11, 5'b01001, 3'b000}) begin
            failures++;
            $display("FAIL stall_hold[%0d] got=%b exp=11101001000", i, {out_valid, out_op, out_data, out_flags});
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL free_slot_in_ready got=%b exp=1", in_ready); end
      collect(5, 60);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({g_op[i], g_data[i], g_flags[i]} !== {t_op[i], t_data[i], t_flags[i]}) begin
            failures++;
            $display("FAIL drain[%0d] got=%b exp=%b", i, {g_op[i], g_data[i], g_flags[i]}, {t_op[i], t_data[i], t_flags[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      t_op[0] = 2'b00; t_a[0] = 4'h3; t_b[0] = 4'h4; t_data[0] = 5'b00111; t_flags[0] = 3'b000;
      t_op[1] = 2'b01; t_a[1] = 4'h0; t_b[1] = 4'h1; t_data[1] = 5'b01111; t_flags[1] = 3'b000;
      t_op[2] = 2'b10; t_a[2] = 4'h5; t_b[2] = 4'h5; t_data[2] = 5'b00000; t_flags[2] = 3'b100;
      t_op[3] = 2'b11; t_a[3] = 4'ha; t_b[3] = 4'hc; t_data[3] = 5'b01000; t_flags[3] = 3'b000;
      t_op[4] = 2'b00; t_a[4] = 4'hf; t_b[4] = 4'h1; t_data[4] = 5'b10000; t_flags[4] = 3'b000;
      t_op[5] = 2'b01; t_a[5] = 4'h8; t_b[5] = 4'h8; t_data[5] = 5'b10000; t_flags[5] = 3'b000;
      t_op[6] = 2'b10; t_a[6] = 4'h1; t_b[6] = 4'h0; t_data[6] = 5'b00000; t_flags[6] = 3'b010;
      t_op[7] = 2'b11; t_a[7] = 4'h7; t_b[7] = 4'he; t_data[7] = 5'b00110; t_flags[7] = 3'b000;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) push_op(t_op[i], t_a[i], t_b[i]);
         end
         begin
            collect(8, 200);
         end
      join
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({g_op[i], g_data[i], g_flags[i]} !== {t_op[i], t_data[i], t_flags[i]}) begin
            failures++;
            $display("FAIL stream[%0d] got=%b exp=%b", i, {g_op[i], g_data[i], g_flags[i]}, {t_op[i], t_data[i], t_flags[i]});
         end
      end
      for (int i = 1; i < 8; i++) begin
         checks++;
         if (g_cyc[i] - g_cyc[i-1] !== 2) begin
            failures++;
            $display("FAIL stream_gap[%0d] got=%0d exp=2", i, g_cyc[i] - g_cyc[i-1]);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = 4'h0;
      in_b      = 4'h0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_reset_mid();
      test_add();
      test_sub();
      test_cmp();
      test_and_stall();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
